motor_step_gen: RTL and testbench

- Avalon-MM 16-bit slave that turns interval-timer timeouts into stepper-driver STEP/DIR/ENABLE signals.
- Sits directly downstream of the system interval timer; its tick_in input is the timer's one-cycle timeout pulse.
- Each tick advances the step-period counter. The block emits a programmed number of step pulses, then raises done/irq for the Nios core.

---
 rtl/motor_pkg.sv | 39 +++
 rtl/motor_step_gen_if.sv | 14 +
 rtl/motor_step_fsm.sv | 123 ++++++++++++
 rtl/motor_step_gen.sv | 136 +++++++++++++
 tb/tb_motor_step_gen.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the stepper step generator: register map, bit indices, FSM states.
package motor_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned DIR_SETUP = 8;

  localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_CONTROL = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_PERIOD  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_PWIDTH  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] ADDR_STEPS_L = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ADDR_STEPS_H = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] ADDR_DONE_L  = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] ADDR_DONE_H  = ADDR_W'(7);

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_DONE  = 1;
  localparam int unsigned ST_FAULT = 2;

  localparam int unsigned CTRL_IRQ_EN = 0;
  localparam int unsigned CTRL_DIR    = 1;
  localparam int unsigned CTRL_START  = 2;
  localparam int unsigned CTRL_STOP   = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_WAIT
  } state_t;

  // A programmed zero behaves as one
  function automatic logic [DATA_W-1:0] at_least_one(input logic [DATA_W-1:0] v);
    return (v == '0) ? DATA_W'(1) : v;
  endfunction

endpackage

// File: rtl/motor_step_gen_if.sv
// Avalon-MM register slave bus of the step generator.
interface motor_step_gen_if;
  import motor_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/motor_step_fsm.sv
// Step sequencer: direction setup, pulse width timing, tick-based step period, progress count.
module motor_step_fsm
  import motor_pkg::*;
#(
  parameter int unsigned SETUP_CYC = DIR_SETUP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              dir,
  input  logic              tick_in,
  input  logic [CNT_W-1:0]  steps,
  input  logic [DATA_W-1:0] period,
  input  logic [DATA_W-1:0] pwidth,
  output logic              busy,
  output logic              step_out,
  output logic              dir_out,
  output logic              done_set_c,
  output logic [CNT_W-1:0]  progress
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] per_q, per_d;
  logic [CNT_W-1:0]  steps_q, steps_d;
  logic [CNT_W-1:0]  prog_d, prog_inc;
  logic              dir_d, busy_d, step_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      per_q    <= DATA_W'(1);
      steps_q  <= '0;
      progress <= '0;
      dir_out  <= 1'b0;
      busy     <= 1'b0;
      step_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      steps_q  <= steps_d;
      progress <= prog_d;
      dir_out  <= dir_d;
      busy     <= busy_d;
      step_out <= step_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    steps_d    = steps_q;
    prog_d     = progress;
    dir_d      = dir_out;
    done_set_c = 1'b0;
    // Progress saturates rather than wrapping
    prog_inc   = (progress == '1) ? progress : progress + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          steps_d = steps;
          dir_d   = dir;
          prog_d  = '0;
          cnt_d   = DATA_W'(SETUP_CYC - 1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          if (steps_q == '0) begin
            state_d    = S_IDLE;
            done_set_c = 1'b1;
          end else begin
            state_d = S_PULSE;
            cnt_d   = pwidth - DATA_W'(1);
          end
        end else begin
          cnt_d = cnt_q - DATA_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          prog_d = prog_inc;
          if (prog_inc == steps_q) begin
            state_d    = S_IDLE;
            done_set_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            per_d   = period;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - DATA_W'(1);
        end
      end
      S_WAIT: begin
        if (tick_in) begin
          if (cnt_q + DATA_W'(1) == per_q) begin
            state_d = S_PULSE;
            cnt_d   = pwidth - DATA_W'(1);
          end else begin
            cnt_d = cnt_q + DATA_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d    = S_IDLE;
      done_set_c = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
    step_d = (state_d == S_PULSE);
  end

endmodule

// File: rtl/motor_step_gen.sv
// Avalon-MM stepper step generator: register file, read mux and progress snapshot.
// Optional end-stop input enabled by defining MOTOR_STEP_LIMIT_EN.
module motor_step_gen
  import motor_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  motor_step_gen_if.slave bus,
  input  logic            tick_in,
`ifdef MOTOR_STEP_LIMIT_EN
  input  logic            limit_n,
`endif
  output logic            step_out,
  output logic            dir_out,
  output logic            enable_out,
  output logic            irq
);

  logic              wr_c, rd_c, ctrl_wr_c, status_wr_c;
  logic              start_req_c, stop_req_c, fsm_start_c, fsm_stop_c;
  logic              fault_set_c, done_set_c, busy;
  logic              irq_en, dir_reg, done, fault;
  logic [DATA_W-1:0] period_q, pwidth_q, steps_l, steps_h, snap_h;
  logic [DATA_W-1:0] readdata_q, rd_mux_c;
  logic [CNT_W-1:0]  progress;

  assign wr_c        = bus.chipselect && !bus.write_n;
  assign rd_c        = bus.chipselect && bus.write_n;
  assign ctrl_wr_c   = wr_c && (bus.address == ADDR_CONTROL);
  assign status_wr_c = wr_c && (bus.address == ADDR_STATUS);
  assign start_req_c = ctrl_wr_c && bus.writedata[CTRL_START] && !bus.writedata[CTRL_STOP];
  assign stop_req_c  = ctrl_wr_c && bus.writedata[CTRL_STOP];

`ifdef MOTOR_STEP_LIMIT_EN
  logic [1:0] lim_sync;
  logic       limit_low;

  always_ff @(posedge clk) begin
    if (reset) lim_sync <= 2'b11;
    else       lim_sync <= {lim_sync[0], limit_n};
  end

  // An active end-stop blocks starts and aborts a running move
  assign limit_low   = !lim_sync[1];
  assign fsm_start_c = start_req_c && !limit_low;
  assign fsm_stop_c  = stop_req_c || (limit_low && busy);
  assign fault_set_c = limit_low && (busy || start_req_c);
  assign irq         = (done || fault) && irq_en;
`else
  assign fsm_start_c = start_req_c;
  assign fsm_stop_c  = stop_req_c;
  assign fault_set_c = 1'b0;
  assign irq         = done && irq_en;
`endif

  motor_step_fsm #(.SETUP_CYC(DIR_SETUP)) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .start      (fsm_start_c),
    .stop       (fsm_stop_c),
    .dir        (bus.writedata[CTRL_DIR]),
    .tick_in    (tick_in),
    .steps      ({steps_h, steps_l}),
    .period     (at_least_one(period_q)),
    .pwidth     (at_least_one(pwidth_q)),
    .busy       (busy),
    .step_out   (step_out),
    .dir_out    (dir_out),
    .done_set_c (done_set_c),
    .progress   (progress)
  );

  assign enable_out   = busy;
  assign bus.readdata = readdata_q;

  always_comb begin
    rd_mux_c = '0;
    if (rd_c) begin
      case (bus.address)
        ADDR_STATUS: begin
          rd_mux_c[ST_BUSY]  = busy;
          rd_mux_c[ST_DONE]  = done;
          rd_mux_c[ST_FAULT] = fault;
        end
        ADDR_CONTROL: begin
          rd_mux_c[CTRL_IRQ_EN] = irq_en;
          rd_mux_c[CTRL_DIR]    = dir_reg;
        end
        ADDR_PERIOD:  rd_mux_c = period_q;
        ADDR_PWIDTH:  rd_mux_c = pwidth_q;
        ADDR_STEPS_L: rd_mux_c = steps_l;
        ADDR_STEPS_H: rd_mux_c = steps_h;
        ADDR_DONE_L:  rd_mux_c = progress[DATA_W-1:0];
        ADDR_DONE_H:  rd_mux_c = snap_h;
        default:      rd_mux_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en     <= 1'b0;
      dir_reg    <= 1'b0;
      period_q   <= DATA_W'(1);
      pwidth_q   <= DATA_W'(4);
      steps_l    <= '0;
      steps_h    <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
      snap_h     <= '0;
      readdata_q <= '0;
    end else begin
      if (wr_c) begin
        case (bus.address)
          ADDR_CONTROL: begin
            irq_en  <= bus.writedata[CTRL_IRQ_EN];
            dir_reg <= bus.writedata[CTRL_DIR];
          end
          ADDR_PERIOD:  period_q <= bus.writedata;
          ADDR_PWIDTH:  pwidth_q <= bus.writedata;
          ADDR_STEPS_L: steps_l  <= bus.writedata;
          ADDR_STEPS_H: steps_h  <= bus.writedata;
          default: ;
        endcase
      end
      // A completion in the same cycle as a STATUS write stays visible
      if (done_set_c)       done <= 1'b1;
      else if (status_wr_c) done <= 1'b0;
      if (fault_set_c)      fault <= 1'b1;
      else if (status_wr_c) fault <= 1'b0;
      if (rd_c && (bus.address == ADDR_DONE_L)) snap_h <= progress[CNT_W-1:DATA_W];
      readdata_q <= rd_mux_c;
    end
  end

endmodule

// File: tb/tb_motor_step_gen.sv
// Scoreboard bench for motor_step_gen: read-data and step-pulse queues checked by monitors.
module tb_motor_step_gen;
  import motor_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_in = 1'b0;
  logic step_out, dir_out, enable_out, irq;
`ifdef MOTOR_STEP_LIMIT_EN
  logic limit_n = 1'b1;
`endif

  motor_step_gen_if bus_if ();

  motor_step_gen dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .tick_in    (tick_in),
`ifdef MOTOR_STEP_LIMIT_EN
    .limit_n    (limit_n),
`endif
    .step_out   (step_out),
    .dir_out    (dir_out),
    .enable_out (enable_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } rd_exp_t;

  typedef struct {
    int width;
    int gap;
  } pulse_t;

  rd_exp_t rd_q[$];
  pulse_t  pulse_q[$];
  rd_exp_t re;
  pulse_t  pe;
  int n_cmp = 0;
  int n_err = 0;
  int tick_gap = 10;
  int tk = 0;

  // Interval-timer model: one-cycle tick every tick_gap clocks
  always @(negedge clk) begin
    if (tk >= tick_gap - 1) begin
      tick_in = 1'b1;
      tk = 0;
    end else begin
      tick_in = 1'b0;
      tk++;
    end
  end

  // Read-data monitor: readdata is due one cycle after a selected read
  logic rd_v = 1'b0;
  always @(posedge clk) rd_v <= !reset && bus_if.chipselect && bus_if.write_n;

  always @(negedge clk) begin
    if (rd_v) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_extra: got %04h, required no read pending", bus_if.readdata);
      end else begin
        re = rd_q.pop_front();
        if (bus_if.readdata !== re.exp) begin
          n_err++;
          $display("FAIL %s: got %04h, required %04h", re.name, bus_if.readdata, re.exp);
        end
      end
    end
  end

  // Step-pulse monitor: width in clocks, gap in ticks seen while step_out low
  int   hi_cnt = 0;
  int   tick_seen = 0;
  int   gap_meas = -1;
  logic last_s = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      hi_cnt = 0;
      tick_seen = 0;
      last_s = 1'b0;
    end else begin
      if (!step_out && last_s) begin
        n_cmp++;
        if (pulse_q.size() == 0) begin
          n_err++;
          $display("FAIL pulse_extra: got width %0d, required no pulse", hi_cnt);
        end else begin
          pe = pulse_q.pop_front();
          if (hi_cnt != pe.width || (pe.gap >= 0 && gap_meas != pe.gap)) begin
            n_err++;
            $display("FAIL pulse_shape: got width %0d gap %0d, required width %0d gap %0d",
                     hi_cnt, gap_meas, pe.width, pe.gap);
          end
        end
        hi_cnt = 0;
        tick_seen = 0;
      end
      if (step_out && !last_s) gap_meas = tick_seen;
      if (step_out) hi_cnt++;
      else if (tick_in) tick_seen++;
      last_s = step_out;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = a;
    bus_if.writedata  = d;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [15:0] exp, input string nm);
    rd_exp_t e;
    e.name = nm;
    e.exp  = exp;
    rd_q.push_back(e);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    bus_if.address    = a;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
  endtask

  task automatic push_pulse(input int w, input int g);
    pulse_t p;
    p.width = w;
    p.gap   = g;
    pulse_q.push_back(p);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (enable_out !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", 32'(enable_out), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_step(input logic lvl, input int max);
    int n = 0;
    while (step_out !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_step", 32'(step_out), 32'(lvl));
  endtask

  task automatic wait_pulses(input int max);
    int n = 0;
    while (pulse_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pulses", 32'(pulse_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = '0;
    bus_if.writedata  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_step", 32'(step_out), 32'd0);
    chk("rst_dir", 32'(dir_out), 32'd0);
    chk("rst_enable", 32'(enable_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_readdata", 32'(bus_if.readdata), 32'd0);
    bus_read(ADDR_STATUS, 16'h0000, "rst_status");
    bus_read(ADDR_PERIOD, 16'h0001, "rst_period");
    bus_read(ADDR_PWIDTH, 16'h0004, "rst_pwidth");
    bus_read(ADDR_STEPS_L, 16'h0000, "rst_steps_l");

    // Five 2-clock pulses, 3 ticks apart, irq masked
    bus_write(ADDR_PERIOD, 16'd3);
    bus_write(ADDR_PWIDTH, 16'd2);
    bus_write(ADDR_STEPS_L, 16'd5);
    bus_write(ADDR_STEPS_H, 16'd0);
    push_pulse(2, -1);
    for (int i = 0; i < 4; i++) push_pulse(2, 3);
    bus_write(ADDR_CONTROL, 16'h0006);
    chk("t1_dir", 32'(dir_out), 32'd1);
    chk("t1_enable", 32'(enable_out), 32'd1);
    wait_idle(600);
    chk("t1_irq_masked", 32'(irq), 32'd0);
    bus_read(ADDR_STATUS, 16'h0002, "t1_status");
    bus_write(ADDR_CONTROL, 16'h0003);
    chk("t1_irq_en", 32'(irq), 32'd1);
    bus_read(ADDR_DONE_L, 16'd5, "t1_done_l");
    bus_read(ADDR_DONE_H, 16'd0, "t1_done_h");
    bus_read(ADDR_CONTROL, 16'h0003, "t1_control");
    chk("t1_dir_hold", 32'(dir_out), 32'd1);

    // Zero steps: done after DIR_SETUP+1 edges, no pulse
    bus_write(ADDR_STATUS, 16'h0000);
    chk("t2_irq_clr", 32'(irq), 32'd0);
    bus_write(ADDR_STEPS_L, 16'd0);
    bus_write(ADDR_CONTROL, 16'h0005);
    chk("t2_enable", 32'(enable_out), 32'd1);
    chk("t2_dir", 32'(dir_out), 32'd0);
    repeat (7) @(negedge clk);
    chk("t2_irq_early", 32'(irq), 32'd0);
    @(negedge clk);
    chk("t2_irq_done", 32'(irq), 32'd1);
    chk("t2_enable_off", 32'(enable_out), 32'd0);
    bus_read(ADDR_STATUS, 16'h0002, "t2_status");

    // 0x0001_0002 steps, stop during the fourth pulse
    bus_write(ADDR_STATUS, 16'h0000);
    bus_write(ADDR_CONTROL, 16'h0000);
    tick_gap = 4;
    bus_write(ADDR_PERIOD, 16'd1);
    bus_write(ADDR_PWIDTH, 16'd6);
    bus_write(ADDR_STEPS_L, 16'h0002);
    bus_write(ADDR_STEPS_H, 16'h0001);
    push_pulse(6, -1);
    push_pulse(6, 1);
    push_pulse(6, 1);
    bus_write(ADDR_CONTROL, 16'h0004);
    wait_pulses(400);
    wait_step(1'b1, 50);
    push_pulse(1, 1);
    bus_write(ADDR_CONTROL, 16'h0008);
    chk("t3_step_stop", 32'(step_out), 32'd0);
    chk("t3_enable_stop", 32'(enable_out), 32'd0);
    bus_read(ADDR_STATUS, 16'h0000, "t3_status");
    bus_read(ADDR_DONE_L, 16'd3, "t3_done_l");
    bus_read(ADDR_DONE_H, 16'd0, "t3_done_h");

    // start|stop together stays idle and keeps progress
    bus_write(ADDR_CONTROL, 16'h000C);
    chk("t4_enable", 32'(enable_out), 32'd0);
    bus_read(ADDR_STATUS, 16'h0000, "t4_status");
    bus_read(ADDR_DONE_L, 16'd3, "t4_done_l");

    // PERIOD 3->1 during the first interval, plus a start while busy
    bus_write(ADDR_PERIOD, 16'd3);
    bus_write(ADDR_PWIDTH, 16'd2);
    bus_write(ADDR_STEPS_L, 16'd4);
    bus_write(ADDR_STEPS_H, 16'd0);
    push_pulse(2, -1);
    push_pulse(2, 3);
    push_pulse(2, 1);
    push_pulse(2, 1);
    bus_write(ADDR_CONTROL, 16'h0004);
    wait_step(1'b1, 50);
    wait_step(1'b0, 50);
    bus_write(ADDR_PERIOD, 16'd1);
    bus_write(ADDR_CONTROL, 16'h0004);
    chk("t5_busy_restart", 32'(enable_out), 32'd1);
    wait_idle(400);
    bus_read(ADDR_DONE_L, 16'd4, "t5_done_l");
    bus_read(ADDR_STATUS, 16'h0002, "t5_status");

    // Reset in the middle of a pulse
    bus_write(ADDR_STATUS, 16'h0000);
    bus_write(ADDR_PWIDTH, 16'd6);
    bus_write(ADDR_STEPS_L, 16'd10);
    bus_write(ADDR_CONTROL, 16'h0006);
    wait_step(1'b1, 50);
    reset = 1'b1;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    bus_if.address    = ADDR_PERIOD;
    @(negedge clk);
    chk("t6_step", 32'(step_out), 32'd0);
    chk("t6_dir", 32'(dir_out), 32'd0);
    chk("t6_enable", 32'(enable_out), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    chk("t6_readdata", 32'(bus_if.readdata), 32'd0);
    reset = 1'b0;
    bus_if.chipselect = 1'b0;
    bus_read(ADDR_PERIOD, 16'd1, "t6_period");
    bus_read(ADDR_PWIDTH, 16'd4, "t6_pwidth");
    bus_read(ADDR_DONE_L, 16'd0, "t6_done_l");
    bus_read(ADDR_STATUS, 16'h0000, "t6_status");

`ifdef MOTOR_STEP_LIMIT_EN
    // End-stop after two pulses aborts the move and raises fault
    bus_write(ADDR_PERIOD, 16'd10);
    bus_write(ADDR_PWIDTH, 16'd2);
    bus_write(ADDR_STEPS_L, 16'd5);
    push_pulse(2, -1);
    push_pulse(2, 10);
    bus_write(ADDR_CONTROL, 16'h0005);
    wait_pulses(400);
    limit_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("t7_enable", 32'(enable_out), 32'd0);
    chk("t7_irq_fault", 32'(irq), 32'd1);
    chk("t7_step", 32'(step_out), 32'd0);
    bus_read(ADDR_STATUS, 16'h0004, "t7_status");
    bus_read(ADDR_DONE_L, 16'd2, "t7_done_l");
    bus_write(ADDR_STATUS, 16'h0000);
    chk("t7_irq_clr", 32'(irq), 32'd0);
    bus_read(ADDR_STATUS, 16'h0000, "t7_status_clr");
    bus_write(ADDR_CONTROL, 16'h0005);
    chk("t7_start_blocked", 32'(enable_out), 32'd0);
    chk("t7_irq_refault", 32'(irq), 32'd1);
    bus_read(ADDR_STATUS, 16'h0004, "t7_status_refault");
    limit_n = 1'b1;
`endif

    repeat (3) @(negedge clk);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("pulse_q_drained", 32'(pulse_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
